// File: rtl/dmem_pkg.sv
// Shared types for the data memory responder: FSM states and load/store width codes.
package dmem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // funct3 encodings for load/store width and signedness
    typedef enum logic [2:0] {
        MODE_B  = 3'b000,
        MODE_H  = 3'b001,
        MODE_W  = 3'b010,
        MODE_BU = 3'b100,
        MODE_HU = 3'b101
    } mem_mode_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads on a 32-bit word.
// Also classifies the access as misaligned or as an illegal mode for its direction.
module mem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  mode,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wword,
    output logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ext_bit,
    output logic        misaligned,
    output logic        illegal
);

    logic [15:0] rhalf;
    logic [7:0]  rbyte;

    // Addressed half/byte sit at the bottom after shifting by the byte offset;
    // a misaligned half is garbage here but is discarded as an error anyway.
    assign rhalf = 16'(rword >> {offset, 3'b000});
    assign rbyte = rhalf[7:0];

    // Decode mode: store lanes, load extension, alignment and legality.
    // Mode 011 has no defined width here, so it is rejected for stores as well as loads.
    always_comb begin
        wword      = wdata;
        wstrb      = 4'b0000;
        rdata      = rword;
        ext_bit    = 1'b0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (mode)
            MODE_B: begin
                wword   = {4{wdata[7:0]}};
                wstrb   = 4'b0001 << offset;
                rdata   = {{24{rbyte[7]}}, rbyte};
                ext_bit = rbyte[7];
            end
            MODE_BU: begin
                rdata   = {24'd0, rbyte};
                illegal = we;
            end
            MODE_H: begin
                wword      = {2{wdata[15:0]}};
                wstrb      = offset[1] ? 4'b1100 : 4'b0011;
                rdata      = {{16{rhalf[15]}}, rhalf};
                ext_bit    = rhalf[15];
                misaligned = offset[0];
            end
            MODE_HU: begin
                rdata      = {16'd0, rhalf};
                misaligned = offset[0];
                illegal    = we;
            end
            MODE_W: begin
                wstrb      = 4'b1111;
                misaligned = (offset != 2'b00);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a valid/ready request/response pair with a
// fixed number of wait states. Handshake: a transfer happens on a rising edge
// where valid and ready are both 1; valid, once raised, holds its payload stable
// until that edge. All outputs are registered, so nothing is combinational from
// req_valid or rsp_ready.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int Width      = 32,
    parameter int Depth      = 256,
    parameter int WaitStates = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [Width-1:0] req_addr,
    input  logic [Width-1:0] req_wdata,
    input  logic [2:0]       req_mode,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [Width-1:0] rsp_rdata,
    output logic             rsp_err,
    output state_t           dbg_state
);

    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [2:0] WaitLast = (WaitStates > 0) ? 3'(WaitStates - 1) : 3'd0;

    state_t           state, next_state;
    logic [2:0]       wait_cnt;
    logic             cap_we;
    logic [Width-1:0] cap_addr, cap_wdata;
    logic [2:0]       cap_mode;
    logic [31:0]      mem [Depth];

    logic             accept, enter_resp, in_idle;
    logic             cur_we;
    logic [Width-1:0] cur_addr, cur_wdata;
    logic [2:0]       cur_mode;
    logic [Width-1:0] word_idx;
    logic [AW-1:0]    word_sel;
    logic             in_range, err;
    logic [31:0]      rword, wword, rdata32;
    logic [3:0]       wstrb;
    logic             ext_bit, misaligned, illegal;
    logic [Width-1:0] rdata_ext;
    logic             req_ready_d, rsp_valid_d, mem_we;

    assign accept    = req_valid && req_ready;
    assign in_idle   = (state == IDLE);
    assign dbg_state = state;

    // With zero wait states RESP is entered on the accept edge, before the capture
    // registers load, so the live request is used while still in IDLE.
    assign cur_we    = in_idle ? req_we    : cap_we;
    assign cur_addr  = in_idle ? req_addr  : cap_addr;
    assign cur_wdata = in_idle ? req_wdata : cap_wdata;
    assign cur_mode  = in_idle ? req_mode  : cap_mode;

    assign word_idx = cur_addr >> 2;
    assign word_sel = word_idx[AW-1:0];
    assign in_range = (word_idx < Width'(Depth));
    assign rword    = in_range ? mem[word_sel] : 32'd0;
    assign err      = misaligned || illegal || !in_range;

    mem_lane_align u_align (
        .we         (cur_we),
        .mode       (cur_mode),
        .offset     (cur_addr[1:0]),
        .wdata      (cur_wdata[31:0]),
        .rword      (rword),
        .wword      (wword),
        .wstrb      (wstrb),
        .rdata      (rdata32),
        .ext_bit    (ext_bit),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    // Widen the 32-bit load result, replicating the sign for signed loads.
    always_comb begin
        rdata_ext       = {Width{ext_bit}};
        rdata_ext[31:0] = rdata32;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = (WaitStates == 0) ? RESP : WAIT;
            WAIT: if (wait_cnt == WaitLast) next_state = RESP;
            RESP: if (rsp_valid && rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output/control decode; the response is launched one edge after entering RESP.
    always_comb begin
        enter_resp  = (state != RESP) && (next_state == RESP);
        req_ready_d = (next_state == IDLE);
        rsp_valid_d = (state == RESP) && !(rsp_valid && rsp_ready);
        mem_we      = enter_resp && cur_we && !err;
    end

    // Request capture, wait counter and registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_mode  <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_mode  <= req_mode;
                wait_cnt  <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 3'd1;
            end
            if (enter_resp) begin
                rsp_err   <= err;
                rsp_rdata <= (err || cur_we) ? '0 : rdata_ext;
            end
        end
    end

    // Storage: cleared on reset, byte-lane write on the edge entering RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) mem[i] <= 32'd0;
        end else if (mem_we) begin
            for (int l = 0; l < 4; l++) begin
                if (wstrb[l]) mem[word_sel][8*l +: 8] <= wword[8*l +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder with WaitStates=1, Depth=256.
module tb_data_mem_responder;
    import dmem_pkg::*;

    localparam int Width      = 32;
    localparam int Depth      = 256;
    localparam int WaitStates = 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_we = 1'b0;
    logic [Width-1:0] req_addr = '0;
    logic [Width-1:0] req_wdata = '0;
    logic [2:0]       req_mode = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [Width-1:0] rsp_rdata;
    logic             rsp_err;
    state_t           dbg_state;

    // Clock
    always #5 clk = ~clk;

    data_mem_responder #(
        .Width      (Width),
        .Depth      (Depth),
        .WaitStates (WaitStates)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_mode  (req_mode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .dbg_state (dbg_state)
    );

    // Expected entry: {check_data, err, data}
    logic [33:0] exp_q[$];
    logic [31:0] model [Depth];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model of one access: updates model memory and gives expected result.
    function automatic void model_step(input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [2:0] mode,
                                       output logic [31:0] rd, output logic err);
        logic [31:0] w, idx;
        logic [7:0]  by;
        logic [15:0] hw;
        idx = addr >> 2;
        rd  = 32'd0;
        case (mode)
            3'b000, 3'b100: err = 1'b0;
            3'b001, 3'b101: err = addr[0];
            3'b010:         err = (addr[1:0] != 2'b00);
            default:        err = 1'b1;
        endcase
        if (we && mode[2]) err = 1'b1;
        if (idx >= Depth) err = 1'b1;
        if (!err) begin
            w  = model[idx[7:0]];
            by = w[8*int'(addr[1:0]) +: 8];
            hw = w[16*int'(addr[1]) +: 16];
            if (we) begin
                case (mode)
                    3'b000:  w[8*int'(addr[1:0]) +: 8] = wdata[7:0];
                    3'b001:  w[16*int'(addr[1]) +: 16] = wdata[15:0];
                    default: w = wdata;
                endcase
                model[idx[7:0]] = w;
            end else begin
                case (mode)
                    3'b000:  rd = {{24{by[7]}}, by};
                    3'b100:  rd = {24'd0, by};
                    3'b001:  rd = {{16{hw[15]}}, hw};
                    3'b101:  rd = {16'd0, hw};
                    default: rd = w;
                endcase
            end
        end
    endfunction

    // Drive one request, collect its response, optionally stalling rsp_ready.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] mode, input logic [31:0] exp_d, input logic exp_e,
                          input int stall);
        logic [33:0] e;
        int cyc;
        @(negedge clk);
        rsp_ready = (stall == 0);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_mode  = mode;
        exp_q.push_back({!we, exp_e, exp_d});
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("req_ready_seen", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_mode  = 3'($urandom_range(0, 7));
        check("req_ready_busy", 32'(req_ready), 32'd0);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rsp_latency", 32'(cyc), 32'(WaitStates + 1));
        if (exp_q.size() == 0) begin
            check("exp_q_underflow", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("rsp_err", 32'(rsp_err), 32'(e[32]));
            if (e[33]) check("rsp_rdata", rsp_rdata, e[31:0]);
            for (int k = 0; k < stall; k++) begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = 32'h10;
                req_wdata = 32'h1234_5678;
                req_mode  = 3'b010;
                @(negedge clk);
                check("stall_valid", 32'(rsp_valid), 32'd1);
                check("stall_rdata", rsp_rdata, e[31:0]);
                check("stall_err", 32'(rsp_err), 32'(e[32]));
                check("stall_req_ready", 32'(req_ready), 32'd0);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    // Directed access: keep the model in step, but expect the given literal values.
    task automatic directed(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] mode, input logic [31:0] exp_d, input logic exp_e,
                            input int stall);
        logic [31:0] rd;
        logic er;
        model_step(we, addr, wdata, mode, rd, er);
        do_txn(we, addr, wdata, mode, exp_d, exp_e, stall);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic        r_we, r_er;
        logic [31:0] r_a, r_d, r_rd;
        logic [2:0]  r_m;

        for (int i = 0; i < Depth; i++) model[i] = 32'd0;

        // Reset state
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // Word store/load
        directed(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0, 0);
        directed(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, 0);
        // Byte store and signed/unsigned byte loads
        directed(1'b1, 32'h13, 32'h0000_0080, 3'b000, 32'h0, 1'b0, 0);
        directed(1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFF_FF80, 1'b0, 0);
        directed(1'b0, 32'h13, 32'h0, 3'b100, 32'h0000_0080, 1'b0, 0);
        directed(1'b0, 32'h10, 32'h0, 3'b010, 32'h80AD_BEEF, 1'b0, 0);
        // Half loads from the upper half, half store to lower half
        directed(1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF_80AD, 1'b0, 0);
        directed(1'b0, 32'h12, 32'h0, 3'b101, 32'h0000_80AD, 1'b0, 0);
        directed(1'b1, 32'h14, 32'hAAAA_7FFF, 3'b001, 32'h0, 1'b0, 0);
        directed(1'b0, 32'h14, 32'h0, 3'b010, 32'h0000_7FFF, 1'b0, 0);
        // Misaligned accesses
        directed(1'b0, 32'h11, 32'h0, 3'b001, 32'h0, 1'b1, 0);
        directed(1'b1, 32'h12, 32'h1111_1111, 3'b010, 32'h0, 1'b1, 0);
        directed(1'b0, 32'h10, 32'h0, 3'b010, 32'h80AD_BEEF, 1'b0, 0);
        // Out of range and illegal store mode
        directed(1'b0, 32'h400, 32'h0, 3'b010, 32'h0, 1'b1, 0);
        directed(1'b1, 32'h10, 32'h0000_0055, 3'b100, 32'h0, 1'b1, 0);
        directed(1'b0, 32'h10, 32'h0, 3'b010, 32'h80AD_BEEF, 1'b0, 0);
        directed(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 0);
        // Backpressure for 5 cycles with a competing request that must be dropped
        directed(1'b0, 32'h10, 32'h0, 3'b010, 32'h80AD_BEEF, 1'b0, 5);
        repeat (3) begin
            @(negedge clk);
            check("no_queued_rsp", 32'(rsp_valid), 32'd0);
        end
        directed(1'b0, 32'h10, 32'h0, 3'b010, 32'h80AD_BEEF, 1'b0, 0);

        // Reset during WAIT of a store
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1;
        req_mode  = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_reset_state", 32'(dbg_state), 32'(WAIT));
        #2;
        reset = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_rdata", rsp_rdata, 32'd0);
        check("abort_rsp_err", 32'(rsp_err), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        for (int i = 0; i < Depth; i++) model[i] = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_abort", 32'(req_ready), 32'd1);
        check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        directed(1'b0, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0, 0);
        directed(1'b0, 32'h10, 32'h0, 3'b010, 32'h0, 1'b0, 0);

        // Random traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            r_we = 1'($urandom_range(0, 1));
            r_m  = 3'($urandom_range(0, 7));
            r_d  = $urandom;
            r_a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(32'h400, 32'h40F))
                                               : 32'($urandom_range(0, 32'h3F));
            if ($urandom_range(0, 1) == 1) r_a[1:0] = 2'b00;
            model_step(r_we, r_a, r_d, r_m, r_rd, r_er);
            do_txn(r_we, r_a, r_d, r_m, r_rd, r_er, 0);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter Width, default 32, meaning data and address width in bits.
REQ-002 SHALL have parameter Depth, default 256, meaning storage size in 32-bit words.
REQ-003 SHALL have parameter WaitStates, default 1, range 0-7, meaning extra cycles between request accept and response.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-008 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, Width bits: byte address.
REQ-010 SHALL have port req_wdata, input, Width bits: store data, LSB-aligned.
REQ-011 SHALL have port req_mode, input, 3 bits: funct3 encoding (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-012 SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-013 SHALL have port rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-014 SHALL have port rsp_rdata, output, Width bits: load result, extended to Width.
REQ-015 SHALL have port rsp_err, output, 1 bit: the request faulted; qualified by rsp_valid.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; the request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-018 SHALL capture req_we, req_addr, req_wdata and req_mode at accept; later input changes have no effect on that request.
REQ-019 SHALL transition IDLE->WAIT on accept when WaitStates>0, or IDLE->RESP when WaitStates=0.
REQ-020 SHALL remain in WAIT for exactly WaitStates cycles using a counter, then transition to RESP.
REQ-021 SHALL assert rsp_valid in the cycle following edge N+1+WaitStates, where N is the accept edge.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-023 SHALL have no combinational path from req_valid or rsp_ready to any output.
REQ-024 SHALL perform a store's memory write on the edge entering RESP, and only if rsp_err=0.
REQ-025 SHALL write only the addressed byte lanes: B uses addr[1:0], H uses addr[1], W writes all four bytes.
REQ-026 SHALL sign-extend load results for B and H, and zero-extend them for BU and HU.
REQ-027 SHALL return the full word for W loads.
REQ-028 SHALL flag a misaligned access as rsp_err=1: H/HU with addr[0]=1, or W with addr[1:0]!=0.
REQ-029 SHALL flag an out-of-range access as rsp_err=1: word index addr>>2 >= Depth.
REQ-030 SHALL flag an illegal mode as rsp_err=1: 011, 110 or 111 for loads, or 100, 101, 110 or 111 for stores.
REQ-031 SHALL on error drive rsp_rdata=0 and leave memory unmodified.
REQ-032 SHALL return read data that reflects the memory contents at the edge entering RESP, including any earlier store.
REQ-033 SHALL ignore req_valid asserted while not in IDLE; no request is queued.

Reset
REQ-034 SHALL on reset=0, asynchronously: force the state to IDLE, clear the wait counter, and drive req_ready=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-035 SHALL clear all memory words to 0 on reset=0.
REQ-036 SHALL abort an in-flight request on reset asserted mid-operation, with no memory write and no response.
REQ-037 SHALL drive req_ready=1 in the first cycle after reset deasserts.

Structure
REQ-038 SHALL place the state enum (IDLE/WAIT/RESP) and the mem_mode_t enum of funct3 codes in a shared package, dmem_pkg.
REQ-039 SHALL implement lane steering and load extension in one combinational sub-module, mem_lane_align.
REQ-040 SHALL contain all storage and the FSM in data_mem_responder itself.

Verification
REQ-041 SHALL verify: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid 2 cycles after accept (WaitStates=1).
REQ-042 SHALL verify: SB addr 0x13 data 0x80, then LB 0x13 -> 0xFFFFFF80, LBU 0x13 -> 0x00000080, LW 0x10 -> 0x80ADBEEF.
REQ-043 SHALL verify: LH addr 0x11 -> rsp_err 1, rsp_rdata 0; SW 0x12 -> rsp_err 1 and a subsequent LW 0x10 is unchanged.
REQ-044 SHALL verify: LW addr 0x400 (Depth=256) -> rsp_err 1; a store with req_mode 100 -> rsp_err 1, no write.
REQ-045 SHALL verify: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready 0 throughout; new req_valid ignored.
REQ-046 SHALL verify: reset pulsed low during WAIT of SW 0x20 data 0x1 -> outputs cleared immediately, then LW 0x20 -> 0x00000000.
